// File: rtl/pmem_arbiter.sv
// pmem_arbiter: arbitrates between the L1 icache and the L1 dcache for one
// burst-mode physical memory port. Only one line transaction runs at a time.
// Read bursts are gathered beat by beat into a line buffer. Write lines are
// sent out of the same buffer, one beat at a time.
module pmem_arbiter #(
    parameter int BURST_LEN        = 4,
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int ADDR_WIDTH       = 32,
    localparam int BURST_WIDTH     = CACHE_LINE_WIDTH / BURST_LEN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_read,
    input  logic [ADDR_WIDTH-1:0]       i_addr,
    output logic [CACHE_LINE_WIDTH-1:0] i_rdata,
    output logic                        i_resp,
    input  logic                        d_read,
    input  logic                        d_write,
    input  logic [ADDR_WIDTH-1:0]       d_addr,
    input  logic [CACHE_LINE_WIDTH-1:0] d_wdata,
    output logic [CACHE_LINE_WIDTH-1:0] d_rdata,
    output logic                        d_resp,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [ADDR_WIDTH-1:0]       pmem_addr,
    output logic [BURST_WIDTH-1:0]      pmem_wdata,
    input  logic [BURST_WIDTH-1:0]      pmem_rdata,
    input  logic                        pmem_resp,
    input  logic                        pmem_error,
    output logic                        err
);

    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int OFFSET_BITS = $clog2(CACHE_LINE_WIDTH / 8);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_READ  = 3'd1,
        D_READ  = 3'd2,
        D_WRITE = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Encodes which requester won the most recent grant.
    localparam logic GRANT_ICACHE = 1'b0;
    localparam logic GRANT_DCACHE = 1'b1;

    state_t                      state_r;
    state_t                      next_s;
    logic                        last_grant_r;
    logic [BEAT_W-1:0]           beat_r;
    logic [CACHE_LINE_WIDTH-1:0] buffer_r;
    logic [ADDR_WIDTH-1:0]       addr_r;
    logic                        pmem_read_r;
    logic                        pmem_write_r;
    logic                        i_resp_r;
    logic                        d_resp_r;
    logic                        err_r;

    logic                        grant_i_s;
    logic                        grant_d_s;
    logic                        in_xfer_s;
    logic                        final_beat_s;
    logic                        d_req_s;

    assign d_req_s = d_read | d_write;

    // Arbitration and next-state selection. RESP never arbitrates, so the
    // pmem strobes are low for at least one cycle between transactions.
    always_comb begin
        next_s       = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        in_xfer_s    = 1'b0;
        final_beat_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_read && d_req_s) begin
                    if (last_grant_r == GRANT_DCACHE) begin
                        grant_i_s = 1'b1;
                    end else begin
                        grant_d_s = 1'b1;
                    end
                end else if (i_read) begin
                    grant_i_s = 1'b1;
                end else if (d_req_s) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                end
                if (grant_i_s) begin
                    next_s = I_READ;
                end else if (grant_d_s) begin
                    // A simultaneous read and write from the dcache is a write.
                    next_s = d_write ? D_WRITE : D_READ;
                end else begin
                    next_s = IDLE;
                end
            end
            I_READ, D_READ, D_WRITE: begin
                in_xfer_s    = 1'b1;
                final_beat_s = pmem_resp && (beat_r == LAST_BEAT);
                if (final_beat_s) begin
                    next_s = RESP;
                end else begin
                    next_s = state_r;
                end
            end
            RESP: begin
                next_s = IDLE;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State, grant bookkeeping, burst datapath, response pulses and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_DCACHE;
            beat_r       <= '0;
            buffer_r     <= '0;
            addr_r       <= '0;
            pmem_read_r  <= 1'b0;
            pmem_write_r <= 1'b0;
            i_resp_r     <= 1'b0;
            d_resp_r     <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r  <= next_s;
            i_resp_r <= 1'b0;
            d_resp_r <= 1'b0;
            if (pmem_error || (d_read && d_write)) begin
                err_r <= 1'b1;
            end
            if (grant_i_s || grant_d_s) begin
                last_grant_r <= grant_i_s ? GRANT_ICACHE : GRANT_DCACHE;
                addr_r       <= (grant_i_s ? i_addr : d_addr) & ADDR_MASK;
                beat_r       <= '0;
                pmem_read_r  <= grant_i_s || !d_write;
                pmem_write_r <= grant_d_s && d_write;
                if (grant_d_s && d_write) begin
                    buffer_r <= d_wdata;
                end
            end else if (in_xfer_s && pmem_resp) begin
                beat_r <= beat_r + BEAT_W'(1);
                if (state_r != D_WRITE) begin
                    buffer_r[BURST_WIDTH*beat_r +: BURST_WIDTH] <= pmem_rdata;
                end
                if (final_beat_s) begin
                    pmem_read_r  <= 1'b0;
                    pmem_write_r <= 1'b0;
                    i_resp_r     <= (last_grant_r == GRANT_ICACHE);
                    d_resp_r     <= (last_grant_r == GRANT_DCACHE);
                end
            end
        end
    end

    assign pmem_read  = pmem_read_r;
    assign pmem_write = pmem_write_r;
    assign pmem_addr  = addr_r;
    // The write beat follows the counter, so beat 0 is on the bus before the first pmem_resp.
    assign pmem_wdata = buffer_r[BURST_WIDTH*beat_r +: BURST_WIDTH];
    assign i_rdata    = buffer_r;
    assign d_rdata    = buffer_r;
    assign i_resp     = i_resp_r;
    assign d_resp     = d_resp_r;
    assign err        = err_r;

endmodule
